// File: rtl/cheshire_eoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cheshire_eoc_pkg
// Purpose  : Shared types and constants for the end-of-computation monitor.
//            The exit-code word carries the EOC flag in bit 0 and the code
//            in bits [31:1].
// Revision : 1.0 - initial release
// ============================================================================
package cheshire_eoc_pkg;

  // Monitor states: IDLE until armed, RUN while watching, then a terminal
  // DONE (software reported) or TIMEOUT (watchdog expired).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } eoc_state_e;

  localparam int unsigned EocFlagBit    = 0;
  localparam int unsigned ExitCodeWidth = 31;

  // Exit-code scratch register (scratch[2]) in the default memory map.
  localparam logic [47:0] DefaultEocAddr = 48'h0000_0300_0008;

  // Only full-word writes count; partial strobes never update the code.
  function automatic logic is_full_word(input logic [3:0] strb);
    return (strb == 4'hF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cheshire_eoc_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : cheshire_eoc_sat_cnt
// Purpose  : Clear/enable up-counter that saturates at all-ones, with a
//            compare output flagging when the count equals TERMINAL.
// Revision : 1.0 - initial release
// ============================================================================
module cheshire_eoc_sat_cnt
  import cheshire_eoc_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  TERMINAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  // Clear has priority over counting; the count holds once it reaches all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;
  assign tc_o    = (r_count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/cheshire_eoc_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cheshire_eoc_monitor
// Purpose  : Snoops register-bus writes to the exit-code scratch register,
//            latches the exit code and flags pass / fail / timeout.
//            Never drives the bus.
// Config   : CHESHIRE_EOC_WATCHDOG_EN - when defined, RUN expires into
//            TIMEOUT after TIMEOUT_CYCLES cycles; otherwise TIMEOUT is
//            unreachable and timeout_o stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module cheshire_eoc_monitor
  import cheshire_eoc_pkg::*;
#(
  parameter int unsigned                ADDR_WIDTH     = 48,
  parameter logic [ADDR_WIDTH-1:0]      EOC_ADDR       = ADDR_WIDTH'(DefaultEocAddr),
  parameter int unsigned                CNT_WIDTH      = 32,
  parameter logic [CNT_WIDTH-1:0]       TIMEOUT_CYCLES = CNT_WIDTH'(10_000_000)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic                     reg_valid_i,
  input  logic                     reg_ready_i,
  input  logic                     reg_write_i,
  input  logic [ADDR_WIDTH-1:0]    reg_addr_i,
  input  logic [31:0]              reg_wdata_i,
  input  logic [3:0]               reg_wstrb_i,
  output logic                     busy_o,
  output logic                     eoc_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [ExitCodeWidth-1:0] exit_code_o,
  output logic [CNT_WIDTH-1:0]     cycles_o
);

  // Count value seen during the last RUN cycle before the watchdog fires.
  localparam logic [CNT_WIDTH-1:0] c_tc_value = TIMEOUT_CYCLES - CNT_WIDTH'(1);

  eoc_state_e               r_state;
  logic                     r_busy;
  logic                     r_eoc;
  logic                     r_pass;
  logic                     r_timeout;
  logic [ExitCodeWidth-1:0] r_exit_code;

  logic                     w_hit;
  logic                     w_eoc_hit;
  logic [ExitCodeWidth-1:0] w_code;
  logic                     w_cnt_clr;
  logic                     w_cnt_en;
  logic                     w_cnt_tc;
  logic                     w_timeout_hit;

  // A completed full-word write to the scratch register; EOC only if flag set.
  assign w_hit     = reg_valid_i & reg_ready_i & reg_write_i &
                     (reg_addr_i == EOC_ADDR) & is_full_word(reg_wstrb_i);
  assign w_eoc_hit = w_hit & reg_wdata_i[EocFlagBit];
  assign w_code    = reg_wdata_i[ExitCodeWidth:1];

  // The cycle counter restarts on every arm that leaves a non-RUN state.
  assign w_cnt_clr = arm_i & (r_state != RUN);
  assign w_cnt_en  = (r_state == RUN);

  cheshire_eoc_sat_cnt #(
    .WIDTH    (CNT_WIDTH),
    .TERMINAL (c_tc_value)
  ) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_cnt_clr),
    .en_i    (w_cnt_en),
    .count_o (cycles_o),
    .tc_o    (w_cnt_tc)
  );

`ifdef CHESHIRE_EOC_WATCHDOG_EN
  assign w_timeout_hit = w_cnt_tc;
`else
  // Without the watchdog the compare output has no consumer; r_timeout then
  // never leaves 0, so timeout_o is effectively tied low.
  logic w_unused_tc;
  assign w_unused_tc   = w_cnt_tc;
  assign w_timeout_hit = 1'b0;
`endif

  // Monitor FSM with registered status outputs; an EOC hit wins over timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_eoc       <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_exit_code <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, TIMEOUT: begin
          if (arm_i) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_eoc       <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
          end
        end
        RUN: begin
          if (w_eoc_hit) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_eoc       <= 1'b1;
            r_pass      <= (w_code == '0);
            r_exit_code <= w_code;
          end else if (w_timeout_hit) begin
            r_state     <= TIMEOUT;
            r_busy      <= 1'b0;
            r_eoc       <= 1'b1;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b1;
            r_exit_code <= '1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign eoc_o       = r_eoc;
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign exit_code_o = r_exit_code;

endmodule
`default_nettype wire
